// File: rtl/srt4_div_ctrl.sv
// Sequencing controller for the radix-4 SRT integer divider: request handshake,
// sign handling, pre-processing/core sequencing, remainder fix-up and result handoff.
module srt4_div_ctrl #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_signed,
  input  logic            in_rem,
  input  logic [DW-1:0]   in_dividend,
  input  logic [DW-1:0]   in_divisor,
  input  logic            kill,
  output logic            pp_start,
  output logic [DW-1:0]   pp_dividend,
  output logic [DW-1:0]   pp_divisor,
  input  logic [CW-1:0]   pp_iterations,
  input  logic [CW-1:0]   pp_recovery,
  output logic            core_load,
  output logic            core_step,
  input  logic [DW-1:0]   core_quo,
  input  logic [DW+2:0]   core_rem,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_result,
  output logic            out_dz
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_FIX, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic            r_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [DW-1:0]   r_mag_a;
  logic [DW-1:0]   r_mag_b;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_rec;
  logic [DW-1:0]   r_result;
  logic            r_dz;

  logic            w_accept;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [DW-1:0]   w_mag_a;
  logic [DW-1:0]   w_mag_b;
  logic            w_div_zero;
  logic            w_ovf;
  logic [DW-1:0]   w_special;
  logic [CW-1:0]   w_shamt;
  logic [DW-1:0]   w_r;
  logic [DW-1:0]   w_fix_q;
  logic [DW-1:0]   w_fix_r;

  assign w_accept   = in_valid & r_in_ready;
  assign w_neg_a    = in_signed & in_dividend[DW-1];
  assign w_neg_b    = in_signed & in_divisor[DW-1];
  assign w_mag_a    = w_neg_a ? -in_dividend : in_dividend;
  assign w_mag_b    = w_neg_b ? -in_divisor  : in_divisor;
  assign w_div_zero = (in_divisor == '0);
  assign w_ovf      = in_signed && (in_dividend == {1'b1, {(DW-1){1'b0}}}) && (in_divisor == '1);
  assign w_special  = w_div_zero ? (in_rem ? in_dividend : '1)
                                 : (in_rem ? '0 : {1'b1, {(DW-1){1'b0}}});

  // The core leaves the remainder scaled by the normalisation shift; undo it here.
  assign w_shamt = CW'(DW) - r_rec;
  assign w_r     = DW'(core_rem >> w_shamt);
  assign w_fix_q = r_neg_q ? -core_quo : core_quo;
  assign w_fix_r = r_neg_r ? -w_r : w_r;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    pp_start  = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_div_zero || w_ovf) ? S_DONE : S_PRE;
      S_PRE: begin
        pp_start  = 1'b1;
        core_load = 1'b1;
        if (kill)                     w_next = S_IDLE;
        else if (pp_iterations == '0) w_next = S_FIX;
        else                          w_next = S_ITER;
      end
      S_ITER: begin
        core_step = 1'b1;
        if (kill)                     w_next = S_IDLE;
        else if (r_cnt == CW'(1))     w_next = S_FIX;
      end
      S_FIX:  w_next = kill ? S_IDLE : S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; the synchronous reset clears every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_rem      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_cnt      <= '0;
      r_rec      <= '0;
      r_result   <= '0;
      r_dz       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rem   <= in_rem;
          r_neg_q <= w_neg_a ^ w_neg_b;
          r_neg_r <= w_neg_a;
          r_mag_a <= w_mag_a;
          r_mag_b <= w_mag_b;
          r_dz    <= w_div_zero;
          if (w_div_zero || w_ovf) r_result <= w_special;
        end
        S_PRE: begin
          r_cnt <= pp_iterations;
          r_rec <= pp_recovery;
        end
        S_ITER: r_cnt <= r_cnt - CW'(1);
        S_FIX:  if (!kill) r_result <= r_rem ? w_fix_r : w_fix_q;
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign pp_dividend = r_mag_a;
  assign pp_divisor  = r_mag_b;
  assign out_result  = r_result;
  assign out_dz      = r_dz;

endmodule

// File: tb/tb_srt4_div_ctrl.sv
// Self-checking bench for srt4_div_ctrl: behavioural pre-processing/core model,
// arithmetic reference for results and latency, directed and randomized requests.
module tb_srt4_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, in_rem, kill;
  logic [31:0] in_dividend, in_divisor;
  logic        pp_start;
  logic [31:0] pp_dividend, pp_divisor;
  logic [15:0] pp_iterations, pp_recovery;
  logic        core_load, core_step;
  logic [31:0] core_quo;
  logic [34:0] core_rem;
  logic        out_valid, out_ready, out_dz;
  logic [31:0] out_result;

  int n_checks = 0;
  int n_fail   = 0;

  // Environment model state for the operation in flight
  logic [31:0] m_a, m_b, m_q, m_r;
  int          m_n = 0, m_rec = 1, steps = 0;
  // Reference expectations
  logic [31:0] e_res;
  logic        e_dz;
  int          e_lat, e_n;
  logic        e_special;

  srt4_div_ctrl #(.DW(32), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed), .in_rem(in_rem),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .kill(kill),
    .pp_start(pp_start), .pp_dividend(pp_dividend), .pp_divisor(pp_divisor),
    .pp_iterations(pp_iterations), .pp_recovery(pp_recovery),
    .core_load(core_load), .core_step(core_step), .core_quo(core_quo), .core_rem(core_rem),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dz(out_dz)
  );

  always #5 clk = ~clk;

  function automatic int bitlen(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  // Radix-4 iteration count after normalisation: 17 for divisor 1, 1 for a 32-bit divisor
  function automatic int iters(input logic [31:0] b);
    return (35 - bitlen(b)) / 2;
  endfunction

  // Pre-processing stage: meaningful values only while started
  always_comb begin
    pp_iterations = 16'h00ff;
    pp_recovery   = 16'h0005;
    if (pp_start) begin
      pp_iterations = 16'(m_n);
      pp_recovery   = 16'(m_rec);
    end
  end

  // Iteration core: results appear only after exactly N steps since the load
  always @(posedge clk) begin
    if (core_load)      steps <= 0;
    else if (core_step) steps <= steps + 1;
  end

  always_comb begin
    core_quo = 32'h5a5a_5a5a;
    core_rem = '1;
    if (steps == m_n) begin
      core_quo = m_q;
      core_rem = 35'(m_r) << (32 - m_rec);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b);
    int n;
    m_a = (sgn && a[31]) ? -a : a;
    m_b = (sgn && b[31]) ? -b : b;
    e_special = 1'b1;
    e_n = 0;
    e_lat = 1;
    e_dz = 1'b0;
    if (b == 32'h0) begin
      e_res = rem ? a : 32'hffff_ffff;
      e_dz  = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
      e_res = rem ? 32'h0 : 32'h8000_0000;
    end else begin
      e_special = 1'b0;
      e_n   = iters(m_b);
      e_lat = e_n + 3;
      if (sgn) begin
        if (rem) e_res = $signed(a) % $signed(b);
        else     e_res = $signed(a) / $signed(b);
      end else begin
        e_res = rem ? a % b : a / b;
      end
      m_n   = e_n;
      m_rec = bitlen(m_b);
      m_q   = m_a / m_b;
      m_r   = m_a % m_b;
    end
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_signed = sgn; in_rem = rem; in_dividend = a; in_divisor = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_dividend = $urandom; in_divisor = $urandom;
  endtask

  task automatic finish_op(input int bp);
    int c, pps, lds, stp;
    logic [31:0] held;
    c = 1; pps = 0; lds = 0; stp = 0;
    while (c < 40) begin
      if (pp_start) begin
        pps++;
        check("pp_dividend", pp_dividend, m_a);
        check("pp_divisor", pp_divisor, m_b);
      end
      if (core_load) lds++;
      if (core_step) stp++;
      if (out_valid) break;
      @(negedge clk);
      c++;
    end
    check("latency", c, e_lat);
    check("pp_start_cycles", pps, e_special ? 0 : 1);
    check("core_load_cycles", lds, e_special ? 0 : 1);
    check("core_step_cycles", stp, e_n);
    check("in_ready_busy", in_ready, 0);
    check("result", out_result, e_res);
    check("out_dz", out_dz, e_dz);
    held = out_result;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, held);
      check("hold_dz", out_dz, e_dz);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
  endtask

  task automatic do_op(input logic sgn, input logic rem, input logic [31:0] a,
                       input logic [31:0] b, input int bp);
    start_op(sgn, rem, a, b);
    finish_op(bp);
  endtask

  // Runs a normal-path operation into its third ITER cycle (negedge of cycle T+4)
  task automatic run_to_iter3(input logic [31:0] a, input logic [31:0] b);
    start_op(1'b0, 1'b0, a, b);
    repeat (3) @(negedge clk);
    check("core_step_iter3", core_step, 1);
  endtask

  initial begin
    logic        sgn, rem;
    logic [31:0] a, b;
    int          seen;
    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_rem = 1'b0; kill = 1'b0;
    in_dividend = '0; in_divisor = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_core_step", core_step, 0);
    check("rst_pp_start", pp_start, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(1'b0, 1'b0, 32'd100, 32'd7, 0);
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 0);
    do_op(1'b1, 1'b0, 32'hffff_fff9, 32'd2, 0);
    do_op(1'b1, 1'b1, 32'hffff_fff9, 32'd2, 0);
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 0);
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'hffff_ffff, 0);
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hffff_ffff, 0);
    do_op(1'b0, 1'b0, 32'hc000_0001, 32'h8000_0000, 5);
    do_op(1'b0, 1'b1, 32'hc000_0001, 32'h8000_0000, 5);

    // kill in the third ITER cycle: no result, step drops next cycle
    run_to_iter3(32'd1000, 32'd3);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_core_step", core_step, 0);
    check("kill_out_valid", out_valid, 0);
    check("kill_in_ready", in_ready, 1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("kill_no_result", seen, 0);

    // synchronous reset mid-ITER clears everything, then a fresh request completes
    run_to_iter3(32'd12345, 32'd10);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_state_outs", {in_ready, pp_start, core_load, core_step, out_valid, out_dz}, 0);
    check("mrst_out_result", out_result, 0);
    check("mrst_pp_operands", {pp_dividend, pp_divisor}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 1);

    for (int k = 0; k < 30; k++) begin
      sgn = 1'($urandom);
      rem = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 255));
        2:       b = -32'($urandom_range(1, 255));
        3:       begin a = 32'h8000_0000; b = 32'hffff_ffff; end
        4:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if (b == 32'h0 && k % 2 == 1) b = 32'd1;
      do_op(sgn, rem, a, b, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srt4_div_ctrl.md
Name: srt4_div_ctrl

Overview:
- Sequencing controller for the radix-4 SRT integer divider.
- Accepts a divide/remainder request over a valid/ready handshake and converts signed operands to magnitudes.
- Drives the normalisation pre-processing stage, captures its iteration count and recovery value, then steps the iteration core the required number of cycles.
- Applies remainder de-normalisation and sign fix-up, and returns the result over a valid/ready handshake. It also handles divide-by-zero, signed overflow and abort without using the core.

Parameters:
- DW, 32, operand and result width. Only 32 is supported, because the pre-processing stage is hard-coded for 32 bits.
- CW, 16, width of the iteration count and recovery fields (DW/2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_signed  in  1  1 = signed (two's complement) operation.
- in_rem  in  1  1 = return the remainder, 0 = return the quotient.
- in_dividend  in  DW  dividend.
- in_divisor  in  DW  divisor.
- kill  in  1  abort the in-flight operation.
- pp_start  out  1  enable to the pre-processing stage.
- pp_dividend  out  DW  dividend magnitude to pre-processing.
- pp_divisor  out  DW  divisor magnitude to pre-processing.
- pp_iterations  in  CW  iteration count from pre-processing.
- pp_recovery  in  CW  recovery value from pre-processing.
- core_load  out  1  one-cycle pulse: the core loads the normalised operands.
- core_step  out  1  the core performs one radix-4 iteration this cycle.
- core_quo  in  DW  final quotient magnitude from the core.
- core_rem  in  DW+3  final non-negative normalised remainder from the core.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DW  quotient or remainder.
- out_dz  out  1  result came from a divide-by-zero.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets the following; it takes precedence over every other input, including mid-operation:
  - state = IDLE.
  - in_ready, pp_start, core_load, core_step, out_valid, out_dz = 0.
  - out_result and all internal registers = 0.
- States: IDLE, PRE, ITER, FIX, DONE.
- in_ready = 1 only in IDLE. A request is accepted on a cycle where in_valid & in_ready (cycle T). On acceptance the controller registers:
  - the operands, in_signed, in_rem;
  - neg_q = in_signed & (dividend[DW-1] ^ divisor[DW-1]);
  - neg_r = in_signed & dividend[DW-1];
  - magnitudes: two's-complement negate when signed and the MSB is 1; |0x80000000| = 0x80000000.
- Special cases, decided at acceptance: IDLE -> DONE, with out_valid=1 at T+1 and the core never started.
  - Divisor = 0: quotient = all ones, remainder = dividend, out_dz=1.
  - Signed, dividend = 0x80000000 and divisor = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, out_dz=0.
- Normal path: IDLE -> PRE.
- PRE (cycle T+1):
  - pp_start=1, with pp_dividend/pp_divisor driven from the registered magnitudes.
  - Latch cnt = pp_iterations and rec = pp_recovery; pulse core_load=1.
  - Next state: ITER.
- ITER:
  - core_step=1 every cycle; cnt decrements each cycle.
  - Leave for FIX in the cycle where cnt==1, so there are exactly N step cycles, T+2 .. T+1+N, where N = the latched iterations (1..17).
  - If the latched N==0 (must not occur for a nonzero divisor), go directly PRE -> FIX with no steps.
- FIX (cycle T+2+N):
  - q = core_quo; r = core_rem >> (DW - rec), truncated to DW bits.
  - Negate q if neg_q; negate r if neg_r.
  - out_result = in_rem ? r : q. Next state: DONE.
- DONE:
  - out_valid=1 (normal path: first valid cycle is T+3+N, total latency N+3).
  - out_result and out_dz are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: go to IDLE, and in_ready=1 on the next cycle. There are no back-to-back accepts in the same cycle as a result handoff.
- kill:
  - In PRE, ITER or FIX: next state is IDLE, no out_valid is ever produced for that operation, and core_step drops in the following cycle.
  - In DONE or IDLE: ignored. A result already valid must still be handed off.
- pp_start, core_load and core_step are 0 in every state other than those listed above.

Test Plan:
- Unsigned 100/7, in_rem=0 then in_rem=1, behavioural core model → pp_iterations=16 latched; core_step high for exactly 16 cycles; out_valid first at T+19; results 14 and 2.
- Signed -7/2 (0xFFFFFFF9 / 2) → pp_dividend=7, pp_divisor=2; quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Unsigned 5/0 → out_valid at T+1, result 0xFFFFFFFF, out_dz=1, no pp_start/core_load pulse. Same with in_rem=1 → result 5.
- Signed 0x80000000 / 0xFFFFFFFF → out_valid at T+1, quotient 0x80000000, remainder 0, out_dz=0.
- Backpressure: divisor 0x80000000 (N=1), out_ready low for 5 cycles → out_valid and out_result stable throughout; in_ready stays 0 until the cycle after the handshake.
- Abort/reset: kill asserted in the 3rd ITER cycle → IDLE next cycle, core_step=0, no out_valid. Repeat with rst_n=0 mid-ITER → all outputs 0 after the edge, and a fresh request then completes correctly.
